// File: rtl/op_pack_pkg.sv
// Shared definitions for the opcode packer: FSM states, word layout constants
// and the default opcode width.
package op_pack_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PUT  = 2'd1,
    OP   = 2'd2
  } op_state_e;

  // Bit 8 of a machine-code word marks an operand (PUT) word.
  localparam int PUT_BIT     = 8;
  localparam int WORD_W      = 9;
  localparam int OPW_DEFAULT = 4;

endpackage

// File: rtl/op_packer.sv
// Opcode packer: captures one request (opcode plus 0..3 operands) and emits
// it as a stream of 9-bit machine-code words, operands first, opcode last.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. Once valid is raised it stays high, and the data it
// qualifies stays stable, until that transfer. ready may change freely.
// Upstream uses req_valid/req_ready; downstream uses mc_valid/mc_ready.
module op_packer
  import op_pack_pkg::*;
#(
  parameter int OPW = OPW_DEFAULT,
  parameter int CW  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OPW-1:0]    req_op,
  input  logic [1:0]        req_nargs,
  input  logic [7:0]        req_arg0,
  input  logic [7:0]        req_arg1,
  input  logic [7:0]        req_arg2,
  output logic              mc_valid,
  input  logic              mc_ready,
  output logic [WORD_W-1:0] mc_word,
  output logic              busy,
  output logic              done,
  output logic [CW-1:0]     word_cnt,
  output op_state_e         dbg_state
);

  op_state_e      r_state;
  op_state_e      w_next_state;
  logic [1:0]     r_idx;
  logic [1:0]     w_next_idx;
  logic [OPW-1:0] r_op;
  logic [1:0]     r_nargs;
  logic [7:0]     r_arg [0:2];
  logic           r_done;
  logic [CW-1:0]  r_word_cnt;
  logic           w_cap;
  logic           w_hs;

  // Everything the outside sees is derived from registered state only, so
  // mc_valid has no path from mc_ready and mc_word cannot move while stalled.
  assign req_ready = (r_state == IDLE);
  assign mc_valid  = (r_state != IDLE);
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign word_cnt  = r_word_cnt;
  assign dbg_state = r_state;

  assign w_cap = req_valid && req_ready;
  assign w_hs  = mc_valid && mc_ready;

  // Next-state: operands are walked by index, then the opcode word closes the request.
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    case (r_state)
      IDLE: begin
        if (w_cap) begin
          w_next_idx   = 2'd0;
          w_next_state = (req_nargs != 2'd0) ? PUT : OP;
        end
      end
      PUT: begin
        if (w_hs) begin
          if ({1'b0, r_idx} + 3'd1 < {1'b0, r_nargs}) begin
            w_next_idx = r_idx + 2'd1;
          end else begin
            w_next_state = OP;
          end
        end
      end
      OP: begin
        if (w_hs) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_idx   = 2'd0;
      end
    endcase
  end

  // Word encoding: operand words carry the flag bit, opcode words are zero-extended.
  always_comb begin
    mc_word = '0;
    case (r_state)
      PUT:     mc_word = {1'b1, r_arg[r_idx]};
      OP:      mc_word = {1'b0, 8'(r_op)};
      default: mc_word = '0;
    endcase
  end

  // State, index and done pulse; done marks the cycle after the opcode word leaves.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_idx   <= 2'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
      r_done  <= (r_state == OP) && w_hs;
    end
  end

  // Request capture: the upstream fields are only looked at on the capture edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op     <= '0;
      r_nargs  <= 2'd0;
      r_arg[0] <= 8'd0;
      r_arg[1] <= 8'd0;
      r_arg[2] <= 8'd0;
    end else if (w_cap) begin
      r_op     <= req_op;
      r_nargs  <= req_nargs;
      r_arg[0] <= req_arg0;
      r_arg[1] <= req_arg1;
      r_arg[2] <= req_arg2;
    end
  end

  // Free-running count of accepted words; wraps silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word_cnt <= '0;
    end else if (w_hs) begin
      r_word_cnt <= r_word_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_op_packer.sv
// Self-checking bench for op_packer: a queue-based model of the words each
// captured request must produce, a per-cycle compare, directed scenarios
// with literal expectations and a long randomized run.
module tb_op_packer;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [1:0]  req_nargs;
  logic [7:0]  req_arg0, req_arg1, req_arg2;
  logic        mc_valid;
  logic        mc_ready;
  logic [8:0]  mc_word;
  logic        busy;
  logic        done;
  logic [11:0] word_cnt;
  op_pack_pkg::op_state_e dbg_state;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Model: pending words of the current request, expected done, expected count.
  logic [8:0] exp_q[$];
  logic       exp_done;
  int         exp_cnt;

  // Observation log of accepted words.
  logic [8:0] log_w[$];
  int         log_c[$];
  int         done_cnt;
  int         done_cyc;
  int         cap_cyc;
  logic       seen_done;
  logic       rdy_rand;

  op_packer #(.OPW(4), .CW(12)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_nargs(req_nargs), .req_arg0(req_arg0), .req_arg1(req_arg1),
    .req_arg2(req_arg2), .mc_valid(mc_valid), .mc_ready(mc_ready),
    .mc_word(mc_word), .busy(busy), .done(done), .word_cnt(word_cnt),
    .dbg_state(dbg_state)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] arg_of(input int i);
    case (i)
      0:       return req_arg0;
      1:       return req_arg1;
      default: return req_arg2;
    endcase
  endfunction

  // Reference model: a request turns into its operand words then its opcode word.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      exp_done = 1'b0;
      exp_cnt  = 0;
    end else begin
      exp_done = 1'b0;
      if (exp_q.size() != 0) begin
        if (mc_ready) begin
          void'(exp_q.pop_front());
          exp_cnt = (exp_cnt + 1) % 4096;
          if (exp_q.size() == 0) exp_done = 1'b1;
        end
      end else if (req_valid) begin
        for (int i = 0; i < int'(req_nargs); i++) exp_q.push_back({1'b1, arg_of(i)});
        exp_q.push_back({5'b00000, req_op});
      end
    end
  end

  // Per-cycle compare plus observation log, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      chk("mc_valid", mc_valid, exp_q.size() != 0);
      chk("mc_word", mc_word, (exp_q.size() != 0) ? exp_q[0] : 9'h000);
      chk("req_ready", req_ready, exp_q.size() == 0);
      chk("busy", busy, exp_q.size() != 0);
      chk("dbg_idle", dbg_state == op_pack_pkg::IDLE, exp_q.size() == 0);
      chk("done", done, exp_done);
      chk("word_cnt", word_cnt, exp_cnt);
      if (mc_valid && mc_ready) begin
        log_w.push_back(mc_word);
        log_c.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Random downstream back-pressure when enabled.
  always @(posedge clk) begin
    if (rdy_rand) begin
      #1 mc_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic clear_log();
    log_w.delete();
    log_c.delete();
    done_cnt = 0;
  endtask

  task automatic drive_req(input logic [3:0] op, input logic [1:0] n,
                           input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2);
    req_op = op; req_nargs = n; req_arg0 = a0; req_arg1 = a1; req_arg2 = a2;
    req_valid = 1'b1;
  endtask

  // Waits until the pending request is captured; returns just after that edge.
  task automatic wait_cap();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        seen_done = done;
        break;
      end
    end
    @(posedge clk); #1;
    cap_cyc = cyc;
    chk("capture_timeout", ok, 1'b1);
  endtask

  task automatic send(input logic [3:0] op, input logic [1:0] n,
                      input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2);
    drive_req(op, n, a0, a1, a2);
    wait_cap();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    chk("idle_timeout", ok, 1'b1);
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; mc_ready = 1'b0; rdy_rand = 1'b0;
    req_op = '0; req_nargs = '0; req_arg0 = '0; req_arg1 = '0; req_arg2 = '0;
    done_cnt = 0; done_cyc = 0; cap_cyc = 0; seen_done = 1'b0;
    #1;
    chk("rst_mc_valid", mc_valid, 1'b0);
    chk("rst_mc_word", mc_word, 9'h000);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_word_cnt", word_cnt, 12'd0);
    chk("rst_done", done, 1'b0);
    @(posedge clk); #1 reset = 1'b1;

    // Three operands, no back-pressure.
    clear_log();
    mc_ready = 1'b1;
    send(4'h5, 2'd3, 8'h12, 8'h34, 8'h56);
    wait_idle();
    chk("s1_nwords", log_w.size(), 4);
    chk("s1_w0", log_w[0], 9'h112);
    chk("s1_w1", log_w[1], 9'h134);
    chk("s1_w2", log_w[2], 9'h156);
    chk("s1_w3", log_w[3], 9'h005);
    chk("s1_latency", log_c[0], cap_cyc);
    chk("s1_back_to_back", log_c[3], log_c[0] + 3);
    chk("s1_done_cnt", done_cnt, 1);
    chk("s1_done_cyc", done_cyc, log_c[3] + 1);
    chk("s1_word_cnt", word_cnt, 12'd4);

    // Opcode only.
    clear_log();
    send(4'hA, 2'd0, 8'hFF, 8'hFF, 8'hFF);
    wait_idle();
    chk("s2_nwords", log_w.size(), 1);
    chk("s2_w0", log_w[0], 9'h00A);
    chk("s2_latency", log_c[0], cap_cyc);
    chk("s2_done_cyc", done_cyc, log_c[0] + 1);
    chk("s2_word_cnt", word_cnt, 12'd5);

    // Stall three cycles on the second operand.
    clear_log();
    mc_ready = 1'b0;
    send(4'h9, 2'd2, 8'hAB, 8'hCD, 8'hEF);
    mc_ready = 1'b1;
    @(posedge clk); #1 mc_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("s3_held_word", mc_word, 9'h1CD);
    chk("s3_held_valid", mc_valid, 1'b1);
    mc_ready = 1'b1;
    wait_idle();
    chk("s3_nwords", log_w.size(), 3);
    chk("s3_w0", log_w[0], 9'h1AB);
    chk("s3_w1", log_w[1], 9'h1CD);
    chk("s3_w2", log_w[2], 9'h009);
    chk("s3_stall_gap", log_c[1], log_c[0] + 4);
    chk("s3_word_cnt", word_cnt, 12'd8);

    // Request held through a busy sequence with fields changing underneath.
    clear_log();
    drive_req(4'h3, 2'd1, 8'h77, 8'h88, 8'h99);
    wait_cap();
    drive_req(4'hC, 2'd2, 8'h01, 8'h02, 8'h03);
    wait_cap();
    req_valid = 1'b0;
    chk("s4_cap_in_done_cycle", seen_done, 1'b1);
    wait_idle();
    chk("s4_nwords", log_w.size(), 5);
    chk("s4_w0", log_w[0], 9'h177);
    chk("s4_w1", log_w[1], 9'h003);
    chk("s4_w2", log_w[2], 9'h101);
    chk("s4_w3", log_w[3], 9'h102);
    chk("s4_w4", log_w[4], 9'h00C);
    chk("s4_done_cnt", done_cnt, 2);

    // Reset after the first operand word.
    clear_log();
    send(4'h6, 2'd3, 8'h21, 8'h22, 8'h23);
    @(posedge clk); #2 reset = 1'b0;
    #1;
    chk("s5_rst_valid", mc_valid, 1'b0);
    chk("s5_rst_cnt", word_cnt, 12'd0);
    chk("s5_rst_ready", req_ready, 1'b1);
    chk("s5_rst_word", mc_word, 9'h000);
    @(posedge clk); #2 reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("s5_no_done", done_cnt, 0);
    chk("s5_no_words", log_w.size(), 1);
    clear_log();
    send(4'h7, 2'd1, 8'h99, 8'h00, 8'h00);
    wait_idle();
    chk("s5_w0", log_w[0], 9'h199);
    chk("s5_w1", log_w[1], 9'h007);
    chk("s5_word_cnt", word_cnt, 12'd2);

    // Random requests preloading 4095 handshakes, then one word wraps the count.
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    rdy_rand = 1'b1;
    begin
      int remaining;
      int n;
      remaining = 4095;
      while (remaining > 0) begin
        n = $urandom_range(0, 3);
        if (n > remaining - 1) n = remaining - 1;
        send(4'($urandom_range(0, 15)), 2'(n), 8'($urandom), 8'($urandom), 8'($urandom));
        remaining = remaining - (n + 1);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end
    wait_idle();
    chk("s6_preload", word_cnt, 12'hFFF);
    send(4'h1, 2'd0, 8'h00, 8'h00, 8'h00);
    wait_idle();
    rdy_rand = 1'b0;
    chk("s6_wrap", word_cnt, 12'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
